hazard_unit: RTL and testbench

Pipeline hazard controller sitting alongside the ID/EX boundary of the five-stage core, directly upstream of the ALU operand forwarding logic. It detects load-use hazards and taken branches resolved in EX, and handles multi-cycle EX operations. It drives the PC, IF/ID and ID/EX pipeline-register enables, flushes and bubbles. Forwarding then handles every remaining RAW case. It also keeps saturating stall and flush cycle counters for performance debug.

---
 rtl/hazard_if.sv | 34 +++
 rtl/hazard_unit.sv | 103 ++++++++++
 tb/tb_hazard_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Pipeline <-> hazard controller signal bundle: ID/EX hazard sources in, stage enables/flushes out.
// id_valid qualifies the ID fields; there is no backpressure, only enables driven back to the pipeline.
interface hazard_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_is_load;
    logic       ex_busy;
    logic       branch_taken;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_bubble;
    logic       exmem_bubble;

    // Pipeline side: presents ID/EX state, consumes the enables.
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_regwrite, ex_is_load, ex_busy, branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_regwrite, ex_is_load, ex_busy, branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use / taken-branch / multi-cycle-EX hazard controller with saturating
// stall and flush cycle counters. Control outputs are combinational.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_if.slave          hif,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic   lu_hazard;
    logic   stall_inc;
    logic   flush_inc;

    // x0 is hardwired zero, so a load targeting it can never be a producer.
    assign lu_hazard = hif.id_valid & hif.ex_is_load & hif.ex_regwrite & (hif.ex_rd != 5'd0) &
                       ((hif.id_uses_rs1 & (hif.ex_rd == hif.id_rs1)) |
                        (hif.id_uses_rs2 & (hif.ex_rd == hif.id_rs2)));

    assign state_dbg = state;

    always_comb begin
        hif.pc_en        = 1'b1;
        hif.ifid_en      = 1'b1;
        hif.ifid_flush   = 1'b0;
        hif.idex_en      = 1'b1;
        hif.idex_bubble  = 1'b0;
        hif.exmem_bubble = 1'b0;
        state_nxt        = state;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;

        case (state)
            RUN, STALL: begin
                state_nxt = RUN;
                if (hif.ex_busy) begin
                    hif.pc_en        = 1'b0;
                    hif.ifid_en      = 1'b0;
                    hif.idex_en      = 1'b0;
                    hif.exmem_bubble = 1'b1;
                    stall_inc        = 1'b1;
                end else if (hif.branch_taken) begin
                    hif.ifid_flush  = 1'b1;
                    hif.idex_bubble = 1'b1;
                    state_nxt       = FLUSH;
                    flush_inc       = 1'b1;
                end else if (lu_hazard && (state == RUN)) begin
                    // Masked in STALL so each load-use inserts exactly one bubble.
                    hif.pc_en       = 1'b0;
                    hif.ifid_en     = 1'b0;
                    hif.idex_bubble = 1'b1;
                    state_nxt       = STALL;
                    stall_inc       = 1'b1;
                end
            end
            FLUSH: begin
                // EX holds a bubble here, so busy/branch cannot be real.
                hif.ifid_flush = 1'b1;
                flush_inc      = 1'b1;
                state_nxt      = RUN;
            end
            default: state_nxt = RUN;
        endcase

        if (!reset) begin
            hif.pc_en        = 1'b0;
            hif.ifid_en      = 1'b0;
            hif.ifid_flush   = 1'b1;
            hif.idex_en      = 1'b0;
            hif.idex_bubble  = 1'b1;
            hif.exmem_bubble = 1'b1;
            state_nxt        = RUN;
            stall_inc        = 1'b0;
            flush_inc        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (stall_inc && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + CNT_ONE;
            if (flush_inc && (flush_cycles != CNT_MAX)) flush_cycles <= flush_cycles + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; each scenario task checks control
// outputs, FSM state and counters against hand-computed values.
module tb_hazard_unit;

    localparam int CNT_W = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble}
    localparam logic [5:0] C_DEF  = 6'b110100;
    localparam logic [5:0] C_LU   = 6'b000110;
    localparam logic [5:0] C_BR   = 6'b111110;
    localparam logic [5:0] C_FL   = 6'b111100;
    localparam logic [5:0] C_BUSY = 6'b000001;
    localparam logic [5:0] C_RST  = 6'b001011;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;
    logic [1:0]       state_dbg;
    logic [5:0]       ctrl;
    int               vectors;
    int               miscompares;

    hazard_if hif ();

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .hif          (hif.slave),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
        .state_dbg    (state_dbg)
    );

    assign ctrl = {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en, hif.idex_bubble, hif.exmem_bubble};

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.id_valid     = 1'b0;
        hif.id_rs1       = 5'd0;
        hif.id_rs2       = 5'd0;
        hif.id_uses_rs1  = 1'b0;
        hif.id_uses_rs2  = 1'b0;
        hif.ex_rd        = 5'd0;
        hif.ex_regwrite  = 1'b0;
        hif.ex_is_load   = 1'b0;
        hif.ex_busy      = 1'b0;
        hif.branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    // Load x5 in EX, ID reads x5 through rs2 (rs1 = x3).
    task automatic drive_load_use();
        hif.id_valid    = 1'b1;
        hif.id_rs1      = 5'd3;
        hif.id_rs2      = 5'd5;
        hif.id_uses_rs1 = 1'b1;
        hif.id_uses_rs2 = 1'b1;
        hif.ex_rd       = 5'd5;
        hif.ex_regwrite = 1'b1;
        hif.ex_is_load  = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        vectors++;
        if (ctrl !== C_RST) begin
            $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RST); miscompares++;
        end
        step();
        vectors++;
        if ({state_dbg, stall_cycles, flush_cycles} !== {S_RUN, 4'd0, 4'd0}) begin
            $display("FAIL reset_state: got st=%0d stall=%0d flush=%0d expected 0/0/0",
                     state_dbg, stall_cycles, flush_cycles); miscompares++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_DEF) begin
            $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, C_DEF); miscompares++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_load_use();
        #1;
        vectors++;
        if (ctrl !== C_LU) begin
            $display("FAIL lu_stall_ctrl: got %b expected %b", ctrl, C_LU); miscompares++;
        end
        step();
        // Hazard inputs still held: STALL must mask them.
        vectors++;
        if (ctrl !== C_DEF || state_dbg !== S_STALL || stall_cycles !== 4'd1) begin
            $display("FAIL lu_stall_state: got ctrl=%b st=%0d stall=%0d expected %b/%0d/1",
                     ctrl, state_dbg, stall_cycles, C_DEF, S_STALL); miscompares++;
        end
        clear_inputs();
        step();
        vectors++;
        if (ctrl !== C_DEF || state_dbg !== S_RUN || stall_cycles !== 4'd1) begin
            $display("FAIL lu_after: got ctrl=%b st=%0d stall=%0d expected %b/0/1",
                     ctrl, state_dbg, stall_cycles, C_DEF); miscompares++;
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int v = 0; v < 5; v++) begin
            drive_load_use();
            case (v)
                0: begin hif.ex_rd = 5'd0; hif.id_rs2 = 5'd0; end
                1: hif.id_uses_rs2 = 1'b0;
                2: begin hif.id_rs1 = 5'd5; hif.id_rs2 = 5'd7; hif.id_uses_rs1 = 1'b0; end
                3: hif.id_valid = 1'b0;
                default: hif.ex_is_load = 1'b0;
            endcase
            #1;
            vectors++;
            if (ctrl !== C_DEF) begin
                $display("FAIL no_hazard_%0d: got %b expected %b", v, ctrl, C_DEF); miscompares++;
            end
            step();
        end
        vectors++;
        if (stall_cycles !== 4'd0 || state_dbg !== S_RUN) begin
            $display("FAIL no_hazard_cnt: got stall=%0d st=%0d expected 0/0", stall_cycles, state_dbg);
            miscompares++;
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        hif.branch_taken = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_BR) begin
            $display("FAIL br_run_ctrl: got %b expected %b", ctrl, C_BR); miscompares++;
        end
        step();
        // Busy and a spurious branch during FLUSH must be ignored.
        hif.ex_busy = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_FL || state_dbg !== S_FLUSH) begin
            $display("FAIL br_flush_ctrl: got ctrl=%b st=%0d expected %b/2", ctrl, state_dbg, C_FL);
            miscompares++;
        end
        clear_inputs();
        step();
        vectors++;
        if (ctrl !== C_DEF || state_dbg !== S_RUN || flush_cycles !== 4'd2 || stall_cycles !== 4'd0) begin
            $display("FAIL br_after: got ctrl=%b st=%0d flush=%0d stall=%0d expected %b/0/2/0",
                     ctrl, state_dbg, flush_cycles, stall_cycles, C_DEF); miscompares++;
        end
    endtask

    task automatic test_busy_priority();
        do_reset();
        drive_load_use();
        hif.branch_taken = 1'b1;
        hif.ex_busy      = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if (ctrl !== C_BUSY) begin
                $display("FAIL busy_cycle_%0d: got %b expected %b", c, ctrl, C_BUSY); miscompares++;
            end
            step();
        end
        vectors++;
        if (stall_cycles !== 4'd4 || flush_cycles !== 4'd0 || state_dbg !== S_RUN) begin
            $display("FAIL busy_cnt: got stall=%0d flush=%0d st=%0d expected 4/0/0",
                     stall_cycles, flush_cycles, state_dbg); miscompares++;
        end
        // Busy drops: the branch wins over the load-use hazard.
        hif.ex_busy = 1'b0;
        #1;
        vectors++;
        if (ctrl !== C_BR) begin
            $display("FAIL busy_then_br: got %b expected %b", ctrl, C_BR); miscompares++;
        end
        step();
        vectors++;
        if (state_dbg !== S_FLUSH || stall_cycles !== 4'd4 || flush_cycles !== 4'd1) begin
            $display("FAIL br_over_lu: got st=%0d stall=%0d flush=%0d expected 2/4/1",
                     state_dbg, stall_cycles, flush_cycles); miscompares++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        drive_load_use();
        step();
        hif.branch_taken = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_BR || state_dbg !== S_STALL) begin
            $display("FAIL stall_br_ctrl: got ctrl=%b st=%0d expected %b/1", ctrl, state_dbg, C_BR);
            miscompares++;
        end
        step();
        vectors++;
        if (state_dbg !== S_FLUSH || stall_cycles !== 4'd1 || flush_cycles !== 4'd1) begin
            $display("FAIL stall_br_state: got st=%0d stall=%0d flush=%0d expected 2/1/1",
                     state_dbg, stall_cycles, flush_cycles); miscompares++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        hif.branch_taken = 1'b1;
        step();
        hif.branch_taken = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (ctrl !== C_RST) begin
            $display("FAIL rst_flush_ctrl: got %b expected %b", ctrl, C_RST); miscompares++;
        end
        step();
        reset = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_DEF || state_dbg !== S_RUN || stall_cycles !== 4'd0 || flush_cycles !== 4'd0) begin
            $display("FAIL rst_flush_after: got ctrl=%b st=%0d stall=%0d flush=%0d expected %b/0/0/0",
                     ctrl, state_dbg, stall_cycles, flush_cycles, C_DEF); miscompares++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 20; n++) begin
            drive_load_use();
            step();
            clear_inputs();
            step();
            if (n == 14) begin
                vectors++;
                if (stall_cycles !== 4'd15) begin
                    $display("FAIL sat_reach: got %0d expected 15", stall_cycles); miscompares++;
                end
            end
        end
        vectors++;
        if (stall_cycles !== 4'd15 || flush_cycles !== 4'd0) begin
            $display("FAIL sat_hold: got stall=%0d flush=%0d expected 15/0", stall_cycles, flush_cycles);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_busy_priority();
        test_branch_in_stall();
        test_reset_mid_flush();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
